countdown_mmss: RTL and testbench



---
 rtl/microondas_pkg.sv | 18 +
 rtl/bin2bcd_99.sv | 9 +
 rtl/countdown_mmss.sv | 80 ++++++++
 tb/tb_countdown_mmss.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// microondas_pkg: time limits, widths and the clamp helper shared by the
// microwave controller, the countdown timer and the display driver.
package microondas_pkg;
    localparam int TIME_W = 7;
    localparam int BCD_W  = 8;
    localparam logic [TIME_W-1:0] MAX_MIN = 7'd99;
    localparam logic [TIME_W-1:0] MAX_SEC = 7'd59;

    typedef struct packed {
        logic [TIME_W-1:0] min;
        logic [TIME_W-1:0] sec;
    } mmss_t;

    function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                     input logic [TIME_W-1:0] max);
        return (v > max) ? max : v;
    endfunction
endpackage

// File: rtl/bin2bcd_99.sv
// bin2bcd_99: binary 0..99 to two-digit packed BCD (tens high, units low).
module bin2bcd_99
    import microondas_pkg::*;
(
    input  logic [TIME_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd
);
    assign bcd = {4'(bin / 7'd10), 4'(bin % 7'd10)};
endmodule

// File: rtl/countdown_mmss.sv
// countdown_mmss: mm:ss countdown, one decrement per TICKS_PER_SEC enabled cycles.
// Defining TIMER_BCD_EN adds combinational min_bcd/sec_bcd outputs.
module countdown_mmss
    import microondas_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [TIME_W-1:0] min_in,
    input  logic [TIME_W-1:0] sec_in,
    input  logic              en,
    output logic [TIME_W-1:0] min_out,
    output logic [TIME_W-1:0] sec_out,
    output logic              running,
`ifdef TIMER_BCD_EN
    output logic [BCD_W-1:0]  min_bcd,
    output logic [BCD_W-1:0]  sec_bcd,
`endif
    output logic              done
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    mmss_t t_q, t_d;
    logic [PW-1:0] pre_q, pre_d;
    logic running_q, running_d, done_q, done_d;
    logic active, tick;

    always_comb begin
        active    = en && (t_q != '0);
        tick      = active && (pre_q == PRE_LAST);
        t_d       = t_q;
        pre_d     = pre_q;
        done_d    = 1'b0;
        running_d = active;
        if (clear) begin
            t_d   = '0;
            pre_d = '0;
        end else if (load) begin
            t_d.min = clamp_time(min_in, MAX_MIN);
            t_d.sec = clamp_time(sec_in, MAX_SEC);
            pre_d   = '0;
        end else if (tick) begin
            pre_d   = '0;
            t_d.sec = (t_q.sec != '0) ? t_q.sec - 7'd1 : MAX_SEC;
            t_d.min = (t_q.sec != '0) ? t_q.min : t_q.min - 7'd1;
            // only 00:01 can reach 00:00 on a tick; 01:00 borrows to 00:59
            done_d  = (t_q.min == '0) && (t_q.sec == 7'd1);
        end else if (active) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_q       <= '0;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            t_q       <= t_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign min_out = t_q.min;
    assign sec_out = t_q.sec;
    assign running = running_q;
    assign done    = done_q;

`ifdef TIMER_BCD_EN
    bin2bcd_99 u_min_bcd (.bin(t_q.min), .bcd(min_bcd));
    bin2bcd_99 u_sec_bcd (.bin(t_q.sec), .bcd(sec_bcd));
`endif
endmodule

// File: tb/tb_countdown_mmss.sv
// tb_countdown_mmss: directed plan scenarios plus random traffic, checked
// every cycle against a total-seconds reference model.
module tb_countdown_mmss;
    localparam int TICKS = 4;

    logic clock, reset, clear, load, en;
    logic [6:0] min_in, sec_in, min_out, sec_out;
    logic running, done;
`ifdef TIMER_BCD_EN
    logic [7:0] min_bcd, sec_bcd;
`endif

    int n_vec, n_bad;
    int m_total, m_pre, m_done, m_run;

    countdown_mmss #(.TICKS_PER_SEC(TICKS)) dut (
        .clock(clock), .reset(reset), .clear(clear), .load(load),
        .min_in(min_in), .sec_in(sec_in), .en(en),
        .min_out(min_out), .sec_out(sec_out), .running(running),
`ifdef TIMER_BCD_EN
        .min_bcd(min_bcd), .sec_bcd(sec_bcd),
`endif
        .done(done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_total = 0; m_pre = 0; m_done = 0; m_run = 0;
        end else begin
            m_run  = (en && m_total != 0) ? 1 : 0;
            m_done = 0;
            if (clear) begin
                m_total = 0; m_pre = 0;
            end else if (load) begin
                m_total = clampi(min_in, 99) * 60 + clampi(sec_in, 59);
                m_pre   = 0;
            end else if (en && m_total != 0) begin
                if (m_pre == TICKS - 1) begin
                    m_pre = 0;
                    m_total--;
                    m_done = (m_total == 0) ? 1 : 0;
                end else m_pre++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        chk("min_out", min_out, m_total / 60);
        chk("sec_out", sec_out, m_total % 60);
        chk("running", running, m_run);
        chk("done", done, m_done);
`ifdef TIMER_BCD_EN
        chk("min_bcd", min_bcd, ((m_total / 60) / 10) * 16 + (m_total / 60) % 10);
        chk("sec_bcd", sec_bcd, ((m_total % 60) / 10) * 16 + (m_total % 60) % 10);
`endif
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load_val(input int mi, input int se);
        load = 1'b1; min_in = 7'(mi); sec_in = 7'(se);
        cyc();
        load = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        m_total = 0; m_pre = 0; m_done = 0; m_run = 0;
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0;
        min_in = '0; sec_in = '0;
        #7;
        chk("rst_min", min_out, 0);
        chk("rst_sec", sec_out, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        #5 reset = 1'b0;

        en = 1'b1;
        load_val(1, 2);
        run(4);  chk("s1_sec_4", sec_out, 1);
        run(4);  chk("s1_sec_8", sec_out, 0);
        run(4);  chk("s1_min_12", min_out, 0); chk("s1_sec_12", sec_out, 59);

        load_val(0, 2);
        run(8);  chk("s2_done", done, 1); chk("s2_sec", sec_out, 0);
        run(1);  chk("s2_done_off", done, 0); chk("s2_running_off", running, 0);

        en = 1'b0;
        load_val(0, 5);
        en = 1'b1; run(2);
        en = 1'b0; run(10); chk("s3_frozen", sec_out, 5);
        en = 1'b1; run(1);  chk("s3_pre1", sec_out, 5);
        run(1);  chk("s3_tick", sec_out, 4);

        load_val(120, 75);
        chk("s4_min", min_out, 99); chk("s4_sec", sec_out, 59);
        load_val(0, 0);
        run(6);  chk("s4_zero_running", running, 0);

        load_val(0, 1);
        run(3);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("s5_clear_done", done, 0); chk("s5_clear_sec", sec_out, 0);
        run(2);  chk("s5_clear_done_late", done, 0);

        load_val(0, 9);
        run(3);
        load_val(0, 7); chk("s5_load_tick", sec_out, 7);
        run(3);  chk("s5_full_period", sec_out, 7);
        run(1);  chk("s5_next_tick", sec_out, 6);

        load_val(2, 0);
        run(5);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_min", min_out, 0);
        chk("s6_async_sec", sec_out, 0);
        chk("s6_async_running", running, 0);
        m_total = 0; m_pre = 0; m_done = 0; m_run = 0;
        cyc();
        reset = 1'b0;
        run(6);  chk("s6_no_resume", sec_out, 0);

        for (int i = 0; i < 1500; i++) begin
            clear = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) en = ~en;
            min_in = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
            sec_in = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
